fwd_hazard_unit: RTL

// - Forwarding/hazard controller for the 5-stage RV64 pipeline; the producer end of the EX-stage forwarding-mux select interface.
// - Tracks the destination registers of in-flight instructions and issues registered SelFwA/SelFwB per instruction entering EX.
// - Drives load-use stalls and the EX bubble, and freezes on data-memory wait.

---
 rtl/fwd_hazard_unit_if.sv | 37 +++
 rtl/fwd_hazard_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// The unit is the master: it produces the EX forwarding selects and the stall controls.
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int STAT_W = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              mem_busy;
  logic [1:0]        SelFwA;
  logic [1:0]        SelFwB;
  logic              stall_ifid;
  logic              bubble_ex;
  logic              freeze;
  logic [STAT_W-1:0] fwd_count;
  logic [STAT_W-1:0] stall_count;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rd, id_regwrite, id_memread, mem_busy,
    output SelFwA, SelFwB, stall_ifid, bubble_ex, freeze,
    output fwd_count, stall_count
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rd, id_regwrite, id_memread, mem_busy,
    input  SelFwA, SelFwB, stall_ifid, bubble_ex, freeze,
    input  fwd_count, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard controller for the 5-stage RV64 pipeline.
// Define FWD_STATS_EN to build the forward/stall statistics counters.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int STAT_W = 32
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.master bus
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } slot_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  slot_t      s_ex, s_mem, s_wb, id_slot;
  state_t     state, saved, eff;
  logic       advance, hz, stall;
  logic [1:0] sel_a_next, sel_b_next;

  function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] rs, input logic use_rs);
    return s.v && s.wr && (s.rd == rs) && (rs != '0) && use_rs;
  endfunction

  // Youngest in-flight producer wins.
  function automatic logic [1:0] pick(input logic [REG_AW-1:0] rs, input logic use_rs,
                                      input slot_t ex, input slot_t mem, input slot_t wb);
    if (hit(ex, rs, use_rs))  return 2'd1;
    if (hit(mem, rs, use_rs)) return 2'd2;
    if (hit(wb, rs, use_rs))  return 2'd3;
    return 2'd0;
  endfunction

  // While waiting on memory, behave as the state we were in when the wait began.
  always_comb begin
    advance = !bus.mem_busy;
    eff     = (state == MEMWAIT) ? saved : state;
    hz      = bus.id_valid && s_ex.v && s_ex.ld && s_ex.wr && (s_ex.rd != '0) &&
              ((bus.id_use_rs1 && (bus.id_rs1 == s_ex.rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == s_ex.rd)));
    stall   = advance && (eff == RUN) && hz;
    sel_a_next = 2'd0;
    sel_b_next = 2'd0;
    id_slot    = '0;
    if (!stall) begin
      sel_a_next = pick(bus.id_rs1, bus.id_use_rs1, s_ex, s_mem, s_wb);
      sel_b_next = pick(bus.id_rs2, bus.id_use_rs2, s_ex, s_mem, s_wb);
      id_slot    = {bus.id_valid, bus.id_rd, bus.id_regwrite, bus.id_memread};
    end
  end

  assign bus.stall_ifid = stall;
  assign bus.bubble_ex  = stall;
  assign bus.freeze     = bus.mem_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ex       <= '0;
      s_mem      <= '0;
      s_wb       <= '0;
      bus.SelFwA <= 2'd0;
      bus.SelFwB <= 2'd0;
      state      <= RUN;
      saved      <= RUN;
    end else if (!advance) begin
      if (state != MEMWAIT) saved <= state;
      state <= MEMWAIT;
    end else begin
      s_wb       <= s_mem;
      s_mem      <= s_ex;
      s_ex       <= id_slot;
      bus.SelFwA <= sel_a_next;
      bus.SelFwB <= sel_b_next;
      state      <= stall ? LDSTALL : RUN;
    end
  end

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] fwd_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else if (advance) begin
      fwd_cnt <= fwd_cnt + STAT_W'(sel_a_next != 2'd0) + STAT_W'(sel_b_next != 2'd0);
      if (stall) stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end

  assign bus.fwd_count   = fwd_cnt;
  assign bus.stall_count = stall_cnt;
`else
  assign bus.fwd_count   = {STAT_W{1'b0}};
  assign bus.stall_count = {STAT_W{1'b0}};
`endif

endmodule
